// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display among four
// requesters. Grants are held for a minimum time before preemption, and
// every ownership change passes through a one-cycle gap with no grant.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no owner; display shows idle_data
// S_GRANT  | owner holds the display; hold counter running
// S_SWITCH | one-cycle break-before-make gap; round-robin pointer moves
module seg7_display_arbiter #(
    parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [127:0] req_data,
    input  logic [31:0]  idle_data,
    input  logic         lock,
    output logic [3:0]   grant,
    output logic [1:0]   owner,
    output logic         disp_valid,
    output logic [31:0]  disp_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    localparam logic [31:0] HOLD_MAX = HOLD_CYCLES - 32'd1;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] disp_data_q, disp_data_d;

    logic [1:0]  pick;
    logic [1:0]  scan_idx;
    logic        any_req;
    logic        others_req;
    logic [31:0] pick_data;
    logic [31:0] owner_data;

    // Round-robin pick: first requester at or after ptr, wrapping mod 4.
    // Scanning from the far end lets the nearest index overwrite the result.
    always_comb begin
        pick     = ptr_q;
        scan_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (req[scan_idx]) begin
                pick = scan_idx;
            end
        end
    end

    assign any_req    = |req;
    assign others_req = |(req & ~(4'b0001 << owner_q));
    assign pick_data  = req_data[{pick, 5'd0} +: 32];
    assign owner_data = req_data[{owner_q, 5'd0} +: 32];

    // Next-state, counter and display-word computation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        disp_data_d = disp_data_q;
        unique case (state_q)
            S_IDLE: begin
                disp_data_d = idle_data;
                if (any_req) begin
                    state_d     = S_GRANT;
                    owner_d     = pick;
                    hold_cnt_d  = 32'd0;
                    disp_data_d = pick_data;
                end
            end
            S_GRANT: begin
                disp_data_d = owner_data;
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
                // Voluntary release always wins; preemption needs a saturated
                // hold counter, a competing request and no lock.
                if (!req[owner_q] ||
                    ((hold_cnt_q == HOLD_MAX) && others_req && !lock)) begin
                    state_d = S_SWITCH;
                    ptr_d   = owner_q + 2'd1;
                end
            end
            S_SWITCH: begin
                if (any_req) begin
                    state_d     = S_GRANT;
                    owner_d     = pick;
                    hold_cnt_d  = 32'd0;
                    disp_data_d = pick_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 2'd0;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= 32'd0;
            disp_data_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            disp_data_q <= disp_data_d;
        end
    end

    assign grant      = (state_q == S_GRANT) ? (4'b0001 << owner_q) : 4'b0000;
    assign owner      = owner_q;
    assign disp_valid = (state_q == S_GRANT);
    assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter with HOLD_CYCLES=4.
// Vectors hold the inputs for one clock and the outputs expected after it.
module tb_seg7_display_arbiter;

    localparam logic [31:0] D1   = 32'h2222_2222;
    localparam logic [31:0] D2   = 32'h3333_3333;
    localparam logic [31:0] D3   = 32'h4444_4444;
    localparam logic [31:0] D0   = 32'h1111_1111;
    localparam logic [31:0] IDLE = 32'h1234_5678;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [31:0]  d0;
    logic [127:0] req_data;
    logic [31:0]  idle_data;
    logic         lock;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         disp_valid;
    logic [31:0]  disp_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic        lock;
        logic [31:0] d0;
        logic [3:0]  g;
        logic [1:0]  o;
        logic        v;
        logic [31:0] dd;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    assign req_data = {D3, D2, D1, d0};

    seg7_display_arbiter #(.HOLD_CYCLES(32'd4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .idle_data  (idle_data),
        .lock       (lock),
        .grant      (grant),
        .owner      (owner),
        .disp_valid (disp_valid),
        .disp_data  (disp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [3:0] r, input logic l, input logic [31:0] dz,
                                input logic [3:0] g, input logic [1:0] o, input logic v,
                                input logic [31:0] dd);
        vec_t e;
        e.req = r; e.lock = l; e.d0 = dz; e.g = g; e.o = o; e.v = v; e.dd = dd;
        tbl.push_back(e);
    endfunction

    task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got grant=%b owner=%0d valid=%b data=%h, want grant=%b owner=%0d valid=%b data=%h",
                     name, act[38:35], act[34:33], act[32], act[31:0],
                     exp[38:35], exp[34:33], exp[32], exp[31:0]);
        end
    endtask

    // Drives every queued vector for one clock; expectations go through the
    // scoreboard and are compared one time unit after the edge.
    task automatic run_table(input string tag);
        vec_t e;
        vec_t x;
        int   n = 0;
        while (tbl.size() > 0) begin
            e = tbl.pop_front();
            req  = e.req;
            lock = e.lock;
            d0   = e.d0;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            x = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, n), {grant, owner, disp_valid, disp_data},
                  {x.g, x.o, x.v, x.dd});
            n++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        req       = 4'b0000;
        lock      = 1'b0;
        d0        = D0;
        idle_data = IDLE;
        #1;
        check("reset_init", {grant, owner, disp_valid, disp_data}, {4'b0, 2'd0, 1'b0, 32'h0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;

        // idle word, single requester, owner data tracking
        add(4'b0000, 0, D0,           4'b0000, 0, 0, IDLE);
        add(4'b0001, 0, 32'hDEADBEEF, 4'b0001, 0, 1, 32'hDEADBEEF);
        add(4'b0001, 0, 32'hCAFE0001, 4'b0001, 0, 1, 32'hCAFE0001);
        run_table("single");

        // asynchronous reset in the middle of a grant
        #3 reset = 1'b0;
        #1;
        check("reset_mid_grant", {grant, owner, disp_valid, disp_data}, {4'b0, 2'd0, 1'b0, 32'h0});
        @(posedge clk); #1;
        check("reset_held", {grant, owner, disp_valid, disp_data}, {4'b0, 2'd0, 1'b0, 32'h0});
        reset = 1'b1;

        add(4'b0000, 0, D0, 4'b0000, 0, 0, IDLE);
        // full contention: 4 grant cycles per owner, one gap cycle between
        for (int i = 0; i < 4; i++) begin
            logic [31:0] dw;
            dw = (i == 0) ? D0 : (i == 1) ? D1 : (i == 2) ? D2 : D3;
            for (int c = 0; c < 4; c++)
                add(4'b1111, 0, D0, 4'b0001 << i, 2'(i), 1, dw);
            add(4'b1111, 0, D0, 4'b0000, 2'(i), 0, dw);
        end
        add(4'b1111, 0, D0, 4'b0001, 0, 1, D0);
        run_table("rotate");

        // voluntary release by owner 2 with owner 3 waiting
        add(4'b1100, 0, D0, 4'b0000, 0, 0, D0);
        add(4'b1100, 0, D0, 4'b0100, 2, 1, D2);
        add(4'b1100, 0, D0, 4'b0100, 2, 1, D2);
        add(4'b1000, 0, D0, 4'b0000, 2, 0, D2);
        add(4'b1000, 0, D0, 4'b1000, 3, 1, D3);
        run_table("release");

        // wrap: after owner 3 releases, 0 wins over 3; 3 served after hold
        add(4'b0001, 0, D0, 4'b0000, 3, 0, D3);
        add(4'b1001, 0, D0, 4'b0001, 0, 1, D0);
        add(4'b1001, 0, D0, 4'b0001, 0, 1, D0);
        add(4'b1001, 0, D0, 4'b0001, 0, 1, D0);
        add(4'b1001, 0, D0, 4'b0001, 0, 1, D0);
        add(4'b1001, 0, D0, 4'b0000, 0, 0, D0);
        add(4'b1001, 0, D0, 4'b1000, 3, 1, D3);
        run_table("wrap");

        // lock keeps owner 0 well past its hold time; dropping it preempts
        add(4'b0011, 0, D0, 4'b0000, 3, 0, D3);
        add(4'b0011, 1, D0, 4'b0001, 0, 1, D0);
        for (int c = 0; c < 22; c++)
            add(4'b0011, 1, D0, 4'b0001, 0, 1, D0);
        add(4'b0011, 0, D0, 4'b0000, 0, 0, D0);
        add(4'b0011, 0, D0, 4'b0010, 1, 1, D1);
        run_table("lock");

        // everyone leaves: gap, idle (data held), then idle word
        add(4'b0000, 0, D0, 4'b0000, 1, 0, D1);
        add(4'b0000, 0, D0, 4'b0000, 1, 0, D1);
        add(4'b0000, 0, D0, 4'b0000, 1, 0, IDLE);
        run_table("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
